sprites_gen: RTL and testbench

- Parametrised sprite engine for the Denise video path.
- Holds NUM_SPR hardware sprites with SPR_W-bit data latches and shifters, and gates shifting with a pixel-clock enable.
- Resolves priority and attachment into one sprite colour index.
- Adds a sticky sprite-group collision register with clear-on-read.
- Feeds the playfield/sprite priority mixer.

---
 rtl/sprites_pkg.sv | 28 ++
 rtl/sprites_gen_if.sv | 10 +
 rtl/sprshift_gen.sv | 74 +++++++
 rtl/sprites_gen.sv | 97 +++++++++
 tb/tb_sprites_gen.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprites_pkg.sv
// Shared constants and helpers for the sprite engine: register offsets,
// default register base, and width/index functions for the output buses.
package sprites_pkg;

  localparam logic [1:0] REG_POS  = 2'd0;
  localparam logic [1:0] REG_CTL  = 2'd1;
  localparam logic [1:0] REG_DATA = 2'd2;
  localparam logic [1:0] REG_DATB = 2'd3;

  localparam logic [8:0] DEFAULT_BASE = 9'h140;

  // Bit position of group pair (p,q), p<q, in lexicographic order over g groups.
  function automatic int pair_idx(input int p, input int q, input int g);
    return p * g - (p * (p + 1)) / 2 + (q - p - 1);
  endfunction

  function automatic int sprdata_w(input int num_spr);
    return $clog2(num_spr / 2) + 2;
  endfunction

  // A single group has no pairs; keep one always-zero bit so the port stays legal.
  function automatic int clx_w(input int num_spr);
    int g;
    g = num_spr / 2;
    return (g * (g - 1) / 2 > 0) ? g * (g - 1) / 2 : 1;
  endfunction

endpackage

// File: rtl/sprites_gen_if.sv
// Register write bus into the sprite engine: address [8:1] and data.
interface sprites_gen_if #(
  parameter int SPR_W = 16
);
  logic [8:1]       reg_address_in;
  logic [SPR_W-1:0] data_in;

  modport master (output reg_address_in, data_in);
  modport slave  (input  reg_address_in, data_in);
endinterface

// File: rtl/sprshift_gen.sv
// One hardware sprite: position/control/data registers, arm and load logic,
// and the pair of output shifters that serialise the sprite's pixel data.
module sprshift_gen
  import sprites_pkg::*;
#(
  parameter int SPR_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [1:0]       reg_sel,
  input  logic [SPR_W-1:0] data_in,
  input  logic [8:0]       hpos,
  input  logic             pix_en,
  output logic [1:0]       d,
  output logic             attach
);

  logic             armed;
  logic             load;
  logic [8:0]       hstart;
  logic [SPR_W-1:0] datla, datlb;
  logic [SPR_W-1:0] shifta, shiftb;

  // NOTE: the data latches are ordinary flops and are cleared with the rest of
  // the state, so a reset can never replay stale sprite data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed  <= 1'b0;
      attach <= 1'b0;
      hstart <= '0;
      datla  <= '0;
      datlb  <= '0;
    end else if (wr_en) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      case (reg_sel)
        REG_POS:  hstart[8:1] <= data_in[7:0];
        REG_CTL: begin
          attach    <= data_in[7];
          hstart[0] <= data_in[0];
          armed     <= 1'b0;
        end
        REG_DATA: begin
          datla <= data_in;
          armed <= 1'b1;
        end
        REG_DATB: datlb <= data_in;
        default:  ;
      endcase
    end
  end

  // Match is registered into load, so the shifter reloads one pixel after the
  // match and its MSB is visible two pixels after hstart.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load   <= 1'b0;
      shifta <= '0;
      shiftb <= '0;
    end else if (pix_en) begin
      load <= armed && (hpos == hstart);
      if (load) begin
        shifta <= datla;
        shiftb <= datlb;
      end else begin
        shifta <= {shifta[SPR_W-2:0], 1'b0};
        shiftb <= {shiftb[SPR_W-2:0], 1'b0};
      end
    end
  end

  assign d = {shiftb[SPR_W-1], shifta[SPR_W-1]};

endmodule

// File: rtl/sprites_gen.sv
// Sprite engine: NUM_SPR sprite shifters, group priority/attach resolution
// into one colour index, and a sticky group-pair collision register.
module sprites_gen
  import sprites_pkg::*;
#(
  parameter int         NUM_SPR = 8,
  parameter int         SPR_W   = 16,
  parameter logic [8:0] BASE    = DEFAULT_BASE
) (
  input  logic                            clk,
  input  logic                            reset_n,
  sprites_gen_if.slave                    bus,
  input  logic [8:0]                      hpos,
  input  logic                            pix_en,
  input  logic                            sprena,
  input  logic [NUM_SPR/2-1:0]            clx_odd_en,
  input  logic                            clx_rd,
  output logic [NUM_SPR-1:0]              nsprite,
  output logic [sprdata_w(NUM_SPR)-1:0]   sprdata,
  output logic [clx_w(NUM_SPR)-1:0]       clxdat
);

  localparam int G  = NUM_SPR / 2;
  localparam int SW = sprdata_w(NUM_SPR);
  localparam int NP = clx_w(NUM_SPR);

  logic       sel;
  logic [2:0] spr_idx;
  logic [1:0] reg_sel;

  assign sel     = (bus.reg_address_in[8:6] == BASE[8:6]);
  assign spr_idx = bus.reg_address_in[5:3];
  assign reg_sel = bus.reg_address_in[2:1];

  logic [1:0]         d [NUM_SPR];
  logic [NUM_SPR-1:0] attach;

  // Only indices below NUM_SPR have an instance, so higher indices are dropped.
  for (genvar i = 0; i < NUM_SPR; i++) begin : g_spr
    sprshift_gen #(.SPR_W(SPR_W)) u_shift (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (sel && (spr_idx == 3'(i))),
      .reg_sel (reg_sel),
      .data_in (bus.data_in),
      .hpos    (hpos),
      .pix_en  (pix_en),
      .d       (d[i]),
      .attach  (attach[i])
    );
  end

  always_comb begin
    nsprite = '0;
    for (int i = 0; i < NUM_SPR; i++) nsprite[i] = sprena && (d[i] != 2'b00);
  end

  logic found;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sprdata = '0;
    found   = 1'b0;
    for (int g = 0; g < G; g++) begin
      if (!found && (nsprite[2*g] || nsprite[2*g+1])) begin
        found = 1'b1;
        if (attach[2*g] || attach[2*g+1])
          sprdata = SW'({d[2*g+1], d[2*g]});
        else if (nsprite[2*g])
          sprdata = SW'((g << 2) | int'(d[2*g]));
        else
          sprdata = SW'((g << 2) | int'(d[2*g+1]));
      end
    end
  end

  logic [G-1:0]  hit;
  logic [NP-1:0] new_hit;

  // Odd sprites take part in collisions only when their group enables them.
  always_comb begin
    hit     = '0;
    new_hit = '0;
    for (int g = 0; g < G; g++)
      hit[g] = (d[2*g] != 2'b00) || (clx_odd_en[g] && (d[2*g+1] != 2'b00));
    for (int p = 0; p < G; p++)
      for (int q = p + 1; q < G; q++)
        new_hit[pair_idx(p, q, G)] = hit[p] && hit[q];
  end

  // A read clears history, but a hit landing in the same cycle survives it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) clxdat <= '0;
    else          clxdat <= (clx_rd ? '0 : clxdat) | ((pix_en && sprena) ? new_hit : '0);
  end

endmodule

// File: tb/tb_sprites_gen.sv
// Directed bench for sprites_gen: a 16-bit and a 32-bit instance share the
// beam inputs; each has its own register bus.
module tb_sprites_gen;

  localparam int POS  = 0;
  localparam int CTL  = 1;
  localparam int DATA = 2;
  localparam int DATB = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [8:0] hpos;
  logic       pix_en, sprena, clx_rd;
  logic [3:0] clx_odd_en;
  logic [7:0] nsprite16, nsprite32;
  logic [3:0] sprdata16, sprdata32;
  logic [5:0] clxdat16, clxdat32;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sprites_gen_if #(.SPR_W(16)) bus16 ();
  sprites_gen_if #(.SPR_W(32)) bus32 ();

  sprites_gen #(.NUM_SPR(8), .SPR_W(16), .BASE(9'h140)) dut16 (
    .clk(clk), .reset_n(reset_n), .bus(bus16), .hpos(hpos), .pix_en(pix_en),
    .sprena(sprena), .clx_odd_en(clx_odd_en), .clx_rd(clx_rd),
    .nsprite(nsprite16), .sprdata(sprdata16), .clxdat(clxdat16)
  );

  sprites_gen #(.NUM_SPR(8), .SPR_W(32), .BASE(9'h140)) dut32 (
    .clk(clk), .reset_n(reset_n), .bus(bus32), .hpos(hpos), .pix_en(pix_en),
    .sprena(sprena), .clx_odd_en(clx_odd_en), .clx_rd(clx_rd),
    .nsprite(nsprite32), .sprdata(sprdata32), .clxdat(clxdat32)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic adv;
    @(posedge clk);
    #1;
  endtask

  task automatic wr16(input int spr, input int r, input logic [15:0] d);
    hpos = 9'h1FF;
    bus16.reg_address_in = 8'(8'hA0 + spr * 4 + r);
    bus16.data_in        = d;
    adv();
    bus16.reg_address_in = 8'h00;
    bus16.data_in        = '0;
  endtask

  task automatic wr32(input int spr, input int r, input logic [31:0] d);
    hpos = 9'h1FF;
    bus32.reg_address_in = 8'(8'hA0 + spr * 4 + r);
    bus32.data_in        = d;
    adv();
    bus32.reg_address_in = 8'h00;
    bus32.data_in        = '0;
  endtask

  task automatic cfg16(input int spr, input logic [15:0] pos, input logic [15:0] ctl,
                       input logic [15:0] datb, input logic [15:0] data);
    wr16(spr, POS, pos);
    wr16(spr, CTL, ctl);
    wr16(spr, DATB, datb);
    wr16(spr, DATA, data);
  endtask

  task automatic sweep(input int lo, input int hi);
    for (int h = lo; h <= hi; h++) begin
      hpos = 9'(h);
      adv();
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    hpos       = 9'h1FF;
    pix_en     = 1'b1;
    sprena     = 1'b1;
    clx_rd     = 1'b0;
    clx_odd_en = 4'b0000;
    bus16.reg_address_in = 8'h00;
    bus16.data_in        = '0;
    bus32.reg_address_in = 8'h00;
    bus32.data_in        = '0;

    adv();
    adv();
    check("reset nsprite16", 32'(nsprite16), 0);
    check("reset sprdata16", 32'(sprdata16), 0);
    check("reset clxdat16",  32'(clxdat16), 0);
    check("reset nsprite32", 32'(nsprite32), 0);
    check("reset clxdat32",  32'(clxdat32), 0);
    reset_n = 1'b1;
    adv();

    // Basic load: hstart 0x80, bit 15 at 0x82, bit 0 at 0x91.
    cfg16(0, 16'h0040, 16'h0000, 16'h0000, 16'h8001);
    for (int h = 'h7E; h <= 'h95; h++) begin
      hpos = 9'(h);
      #2;
      check($sformatf("basic sprdata h=%0h", h), 32'(sprdata16), (h == 'h82 || h == 'h91) ? 1 : 0);
      if (h == 'h82) check("basic nsprite", 32'(nsprite16), 32'h01);
      adv();
    end

    // CTL disarms: the next line shows nothing.
    wr16(0, CTL, 16'h0000);
    for (int h = 'h7E; h <= 'h95; h++) begin
      hpos = 9'(h);
      #2;
      check($sformatf("disarm sprdata h=%0h", h), 32'(sprdata16), 0);
      adv();
    end

    // 32-bit fetch width: four pixels from hstart+2, then bit 0 at pixel 31.
    wr32(0, POS, 32'h0000_0040);
    wr32(0, CTL, 32'h0000_0000);
    wr32(0, DATB, 32'h0000_0000);
    wr32(0, DATA, 32'hF000_0001);
    for (int h = 'h80; h <= 'hA4; h++) begin
      hpos = 9'(h);
      #2;
      check($sformatf("w32 sprdata h=%0h", h), 32'(sprdata32),
            ((h >= 'h82 && h <= 'h85) || h == 'hA1) ? 1 : 0);
      adv();
    end

    // Attach: sprites 0/1 attached with d0=01, d1=10; sprite 2 also visible.
    cfg16(0, 16'h0020, 16'h0080, 16'h0000, 16'h8000);
    cfg16(1, 16'h0020, 16'h0000, 16'h8000, 16'h0000);
    cfg16(2, 16'h0020, 16'h0000, 16'h0000, 16'h8000);
    sweep('h40, 'h41);
    hpos = 9'h042;
    #2;
    check("attach sprdata", 32'(sprdata16), 32'h9);
    check("attach nsprite", 32'(nsprite16), 32'h07);
    adv();
    check("group0/1 clxdat", 32'(clxdat16), 32'h01);

    // Attach cleared: group 0 shows the even sprite.
    wr16(0, CTL, 16'h0000);
    wr16(0, DATA, 16'h8000);
    sweep('h40, 'h41);
    hpos = 9'h042;
    #2;
    check("no-attach sprdata", 32'(sprdata16), 32'h1);
    adv();

    // Sprite 3 alone: group 1, odd sprite, d3=11.
    wr16(0, CTL, 16'h0000);
    wr16(1, CTL, 16'h0000);
    wr16(2, CTL, 16'h0000);
    cfg16(3, 16'h0020, 16'h0000, 16'h8000, 16'h8000);
    sweep('h40, 'h41);
    hpos = 9'h042;
    #2;
    check("spr3 sprdata", 32'(sprdata16), 32'h7);
    check("spr3 nsprite", 32'(nsprite16), 32'h08);
    sprena = 1'b0;
    #1;
    check("sprena off nsprite", 32'(nsprite16), 0);
    check("sprena off sprdata", 32'(sprdata16), 0);
    sprena = 1'b1;
    adv();

    // Half-rate pixels: pix_en low then high for each hpos; 0xA000 gives 1,0,1.
    wr16(3, CTL, 16'h0000);
    cfg16(0, 16'h0040, 16'h0000, 16'h0000, 16'hA000);
    for (int h = 'h80; h <= 'h86; h++) begin
      hpos   = 9'(h);
      pix_en = 1'b0;
      #2;
      check($sformatf("halfrate lo h=%0h", h), 32'(sprdata16), (h == 'h82 || h == 'h84) ? 1 : 0);
      adv();
      pix_en = 1'b1;
      #2;
      check($sformatf("halfrate hi h=%0h", h), 32'(sprdata16), (h == 'h82 || h == 'h84) ? 1 : 0);
      adv();
    end

    // Collisions: clear, then groups 0 and 2 overlap.
    wr16(0, CTL, 16'h0000);
    clx_rd = 1'b1;
    adv();
    clx_rd = 1'b0;
    #2;
    check("clx_rd clears", 32'(clxdat16), 0);
    cfg16(0, 16'h0010, 16'h0000, 16'h0000, 16'h8000);
    cfg16(4, 16'h0010, 16'h0000, 16'h0000, 16'h8000);
    sweep('h20, 'h23);
    check("clx groups 0,2", 32'(clxdat16), 32'h02);
    clx_rd = 1'b1;
    adv();
    clx_rd = 1'b0;
    #2;
    check("clx_rd clears again", 32'(clxdat16), 0);

    // Odd sprite 1 against group 2: counted only with clx_odd_en[0].
    wr16(0, CTL, 16'h0000);
    cfg16(1, 16'h0010, 16'h0000, 16'h0000, 16'h8000);
    sweep('h20, 'h23);
    check("clx odd disabled", 32'(clxdat16), 0);
    clx_odd_en = 4'b0001;
    sweep('h20, 'h23);
    check("clx odd enabled", 32'(clxdat16), 32'h02);

    // Read strobe coinciding with a (1,3) hit keeps only the new bit.
    cfg16(2, 16'h0018, 16'h0000, 16'h0000, 16'h8000);
    cfg16(6, 16'h0018, 16'h0000, 16'h0000, 16'h8000);
    sweep('h30, 'h31);
    hpos   = 9'h032;
    clx_rd = 1'b1;
    adv();
    clx_rd = 1'b0;
    #2;
    check("clx_rd with hit", 32'(clxdat16), 32'h10);

    // Reset mid-shift: outputs drop without waiting for a clock edge.
    cfg16(0, 16'h0020, 16'h0000, 16'h0000, 16'hFFFF);
    sweep('h40, 'h44);
    hpos = 9'h045;
    #2;
    check("pre-reset sprdata", 32'(sprdata16), 32'h1);
    reset_n = 1'b0;
    #1;
    check("async reset sprdata", 32'(sprdata16), 0);
    check("async reset nsprite", 32'(nsprite16), 0);
    check("async reset clxdat", 32'(clxdat16), 0);
    adv();
    adv();
    reset_n = 1'b1;
    for (int h = 'h40; h <= 'h50; h++) begin
      hpos = 9'(h);
      #2;
      check($sformatf("post-reset idle h=%0h", h), 32'(sprdata16), 0);
      adv();
    end

    // A DATA write re-arms; hstart is back at 0 after reset.
    wr16(0, DATA, 16'h8000);
    for (int h = 0; h <= 3; h++) begin
      hpos = 9'(h);
      #2;
      check($sformatf("rearm sprdata h=%0h", h), 32'(sprdata16), (h == 2) ? 1 : 0);
      adv();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
